sdcard_cmd_engine: RTL
======================

# sdcard_cmd_engine

Command-line engine for the SD card controller. It serialises a 48-bit SD command frame onto the CMD line and optionally captures a 48-bit response. The CMD line is paced by the SD clock produced by the upstream clock generator (`sd_clk_i`, registered in the `PCLK_i` domain). The block computes CRC7 for transmit, checks the response, and reports completion and error flags to the register/host layer.

## Interface
Parameters:
- `RESP_TIMEOUT`, default 64: SD-clock rising edges to wait for a response start bit (NCR limit).

Ports:
- `PCLK_i` input 1: system clock.
- `PRESETn_i` input 1: reset, asynchronous, active-low.
- `sd_clk_i` input 1: SD clock from the clock generator, synchronous to `PCLK_i`.
- `cmd_start` input 1: start request, single-cycle pulse.
- `cmd_index` input 6: command index.
- `cmd_arg` input 32: command argument.
- `resp_type` input 2: response type. 00 none, 01 R1/R6/R7 (index and CRC checked), 10 R3/R2-short (index and CRC ignored), 11 reserved (treated as 00).
- `cmd_i` input 1: CMD line input.
- `cmd_o` output 1: CMD line drive value.
- `cmd_oe_o` output 1: CMD line output enable.
- `busy` output 1: command in progress.
- `done` output 1: single-cycle completion pulse.
- `resp_index` output 6: received index field.
- `resp_arg` output 32: received 32-bit payload.
- `crc_err` output 1: response CRC7 mismatch.
- `timeout_err` output 1: no response start bit received.
- `index_err` output 1: index mismatch, or transmission bit not 0.
- `end_bit_err` output 1: response end bit not 1.

## Operation
- Edge detection: `sd_clk_q` holds the value of `sd_clk_i` registered one cycle earlier.
  - Falling edge `fe` = `sd_clk_q & ~sd_clk_i`.
  - Rising edge `re` = `~sd_clk_q & sd_clk_i`.
- Transmit frame, 48 bits, MSB first:
  - start bit 0, transmission bit 1, `cmd_index[5:0]`, `cmd_arg[31:0]`, CRC7[6:0], end bit 1.
  - CRC7 uses polynomial x^7+x^3+1, initial value 0, computed over the first 40 bits.
- States:
  - IDLE: waits for a start request.
  - TX: shifts the frame out.
  - TURN: releases the CMD line.
  - WAIT_RSP: waits for the response start bit.
  - RX: shifts the response in.
- IDLE → TX:
  - Taken on `cmd_start`.
  - Latches `cmd_index`, `cmd_arg` and `resp_type`.
  - Clears all four error flags.
  - `busy`=1 from the next cycle.
- TX:
  - Each `fe` drives the next bit on `cmd_o` with `cmd_oe_o`=1.
  - The first bit is driven at the first `fe` after acceptance.
  - After bit 48 has been driven, go to TURN.
- TURN:
  - At the next `fe`, set `cmd_oe_o`=0 and `cmd_o`=1.
  - If `resp_type` is 00 or 11, return to IDLE with `done`.
  - Otherwise go to WAIT_RSP with the timeout counter at 0.
- WAIT_RSP:
  - Each `re` samples `cmd_i`.
  - If the sample is 0, go to RX; this sample is the start bit.
  - Otherwise increment the counter.
  - When the counter reaches `RESP_TIMEOUT`, set `timeout_err`=1 and return to IDLE with `done`.
- RX:
  - Sample 47 further bits, one per `re`, into a shift register; response CRC7 is computed over the first 40 bits.
  - After the last bit, update `resp_index` and `resp_arg`, then set flags:
    - `index_err`: transmission bit ≠ 0, or (`resp_type`=01 and index ≠ latched `cmd_index`).
    - `crc_err`: `resp_type`=01 and CRC mismatch.
    - `end_bit_err`: end bit ≠ 1.
  - Return to IDLE with `done`.
- Error flags and response registers hold their values until the next accepted `cmd_start`.

Boundary rules:
- `cmd_start` while `busy`=1 is ignored and has no side effects.
- `cmd_start` in the cycle `done` is asserted (state is IDLE) is accepted.
- If `sd_clk_i` stops, the engine stalls in its current state. There is no PCLK-based timeout; the host aborts via reset.
- Reset mid-command: all state goes to IDLE and the line is released immediately (asynchronous).
- `fe` and `re` cannot occur in the same cycle.

## Timing
- Reset values: `cmd_o`=1, `cmd_oe_o`=0, `busy`=0, `done`=0, `resp_index`=0, `resp_arg`=0, all error flags 0.
- `busy` rises 1 cycle after `cmd_start` and falls in the same cycle that `done` pulses.
- `cmd_o` and `cmd_oe_o` change 1 PCLK cycle after the `sd_clk_i` falling edge, because edge detection is registered.
- No response: `done` pulses 1 cycle after the `fe` that releases the line, i.e. 49 SD-clock falling edges after acceptance.
- With response: `done` pulses 1 cycle after the `re` that samples the end bit. Flags and `resp_*` are valid in that same cycle.

## Configuration
- Macro: `SDCARD_CMD_RESP_CRC_EN`.
- Defined: response CRC7 generator and `crc_err` are implemented as above.
- Undefined: no response CRC logic. `crc_err` is tied to 0. Transmit CRC is always present.

## Test plan
- CMD0: `cmd_index`=0, `cmd_arg`=0, `resp_type`=00 → CMD line carries 0x400000000095 MSB first, `cmd_oe_o` drops after the end bit, `done` pulses, all errors 0.
- CMD8: `cmd_arg`=0x000001AA, `resp_type`=01; card returns 0x08000001AA13 → frame 0x48000001AA87 transmitted, `resp_index`=8, `resp_arg`=0x000001AA, no errors.
- Same as CMD8 but response CRC byte 0x15 → `crc_err`=1, other flags 0; with `SDCARD_CMD_RESP_CRC_EN` undefined → `crc_err`=0.
- R3: `resp_type`=10; card returns 0x3F00FF8000FF → `resp_arg`=0x00FF8000, `index_err`=0, `crc_err`=0.
- `resp_type`=01, `cmd_i` held at 1 → after exactly 64 `re` in WAIT_RSP, `timeout_err`=1 and `done` pulses; a second `cmd_start` pulsed during TX is ignored.
- Assert `PRESETn_i` during RX bit 20 → outputs return to reset values immediately; a subsequent CMD0 completes normally.

Source files
------------

// File: rtl/sdcard_cmd_engine.sv
// -----------------------------------------------------------------------------
// sdcard_cmd_engine
//
// Serialises a 48-bit SD command frame (start, transmission bit, index,
// argument, CRC7, end) onto the CMD line, paced by the SD clock, and
// optionally captures and checks a 48-bit response.
//
// Ports:
//   PCLK_i, PRESETn_i  system clock, asynchronous active-low reset
//   sd_clk_i           SD clock from the clock generator (PCLK_i-synchronous)
//   cmd_start          single-cycle start request (ignored while busy)
//   cmd_index/cmd_arg  command fields, latched on acceptance
//   resp_type          00 none, 01 checked short response, 10 unchecked
//                      short response, 11 treated as none
//   cmd_i/cmd_o/cmd_oe_o  CMD line input, drive value and output enable
//   busy, done         command in progress / single-cycle completion pulse
//   resp_index/resp_arg   fields of the last received response
//   crc_err, timeout_err, index_err, end_bit_err   completion status
//
// Configuration:
//   SDCARD_CMD_RESP_CRC_EN  when defined, the response CRC7 is checked and
//                           crc_err is live; otherwise crc_err is tied to 0.
// -----------------------------------------------------------------------------
module sdcard_cmd_engine #(
  parameter int unsigned RESP_TIMEOUT = 64
) (
  input  logic        PCLK_i,
  input  logic        PRESETn_i,
  input  logic        sd_clk_i,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [1:0]  resp_type,
  input  logic        cmd_i,
  output logic        cmd_o,
  output logic        cmd_oe_o,
  output logic        busy,
  output logic        done,
  output logic [5:0]  resp_index,
  output logic [31:0] resp_arg,
  output logic        crc_err,
  output logic        timeout_err,
  output logic        index_err,
  output logic        end_bit_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_TX, S_TURN, S_WAIT_RSP, S_RX
  } state_t;

  localparam int unsigned TW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(RESP_TIMEOUT - 1);

  // CRC7, polynomial x^7 + x^3 + 1, one bit per call, MSB first.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0] crc;
    crc = '0;
    for (int i = 39; i >= 0; i--) crc = crc7_step(crc, d[i]);
    return crc;
  endfunction

  state_t        state, state_n;
  logic          sd_clk_q;
  logic          fe, re;
  logic [47:0]   tx_sr;
  logic [45:0]   rx_sr;
  logic [5:0]    bit_cnt;
  logic [TW-1:0] to_cnt;
  logic [5:0]    lat_index;
  logic [1:0]    lat_type;

  logic accept, tx_shift, line_release, to_inc, to_hit;
  logic rx_begin, rx_shift, rx_last, done_n;

  assign fe   = sd_clk_q & ~sd_clk_i;
  assign re   = ~sd_clk_q & sd_clk_i;
  assign busy = (state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) state <= S_IDLE;
    else            state <= state_n;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n      = state;
    accept       = 1'b0;
    tx_shift     = 1'b0;
    line_release = 1'b0;
    to_inc       = 1'b0;
    to_hit       = 1'b0;
    rx_begin     = 1'b0;
    rx_shift     = 1'b0;
    rx_last      = 1'b0;
    done_n       = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_start) begin
          accept  = 1'b1;
          state_n = S_TX;
        end
      end
      S_TX: begin
        if (fe) begin
          tx_shift = 1'b1;
          if (bit_cnt == 6'd47) state_n = S_TURN;
        end
      end
      S_TURN: begin
        if (fe) begin
          line_release = 1'b1;
          // 00 and the reserved 11 both mean "no response expected".
          if (lat_type == 2'b01 || lat_type == 2'b10) begin
            state_n = S_WAIT_RSP;
          end else begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end
        end
      end
      S_WAIT_RSP: begin
        if (re) begin
          if (!cmd_i) begin
            rx_begin = 1'b1;
            state_n  = S_RX;
          end else if (to_cnt == TO_LAST) begin
            to_hit  = 1'b1;
            done_n  = 1'b1;
            state_n = S_IDLE;
          end else begin
            to_inc = 1'b1;
          end
        end
      end
      S_RX: begin
        if (re) begin
          rx_shift = 1'b1;
          if (bit_cnt == 6'd46) begin
            rx_last = 1'b1;
            done_n  = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // On the final sample rx_sr holds transmission bit, index, argument and
  // CRC (46 bits); the end bit is the cmd_i value being sampled now.
  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      sd_clk_q    <= 1'b0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      bit_cnt     <= '0;
      to_cnt      <= '0;
      lat_index   <= '0;
      lat_type    <= '0;
      cmd_o       <= 1'b1;
      cmd_oe_o    <= 1'b0;
      done        <= 1'b0;
      resp_index  <= '0;
      resp_arg    <= '0;
      timeout_err <= 1'b0;
      index_err   <= 1'b0;
      end_bit_err <= 1'b0;
    end else begin
      sd_clk_q <= sd_clk_i;
      done     <= done_n;
      if (accept) begin
        tx_sr       <= {2'b01, cmd_index, cmd_arg,
                        crc7_40({2'b01, cmd_index, cmd_arg}), 1'b1};
        bit_cnt     <= '0;
        lat_index   <= cmd_index;
        lat_type    <= resp_type;
        timeout_err <= 1'b0;
        index_err   <= 1'b0;
        end_bit_err <= 1'b0;
      end
      if (tx_shift) begin
        cmd_o    <= tx_sr[47];
        cmd_oe_o <= 1'b1;
        tx_sr    <= {tx_sr[46:0], 1'b0};
        bit_cnt  <= bit_cnt + 6'd1;
      end
      if (line_release) begin
        cmd_o    <= 1'b1;
        cmd_oe_o <= 1'b0;
        to_cnt   <= '0;
      end
      if (to_inc) to_cnt <= to_cnt + 1'b1;
      if (to_hit) timeout_err <= 1'b1;
      if (rx_begin) bit_cnt <= '0;
      if (rx_shift) begin
        rx_sr   <= {rx_sr[44:0], cmd_i};
        bit_cnt <= bit_cnt + 6'd1;
      end
      if (rx_last) begin
        resp_index  <= rx_sr[44:39];
        resp_arg    <= rx_sr[38:7];
        index_err   <= rx_sr[45] | ((lat_type == 2'b01) && (rx_sr[44:39] != lat_index));
        end_bit_err <= ~cmd_i;
      end
    end
  end

`ifdef SDCARD_CMD_RESP_CRC_EN
  // The start bit is 0 and the CRC starts at 0, so skipping it leaves the
  // result unchanged; the CRC covers the 39 bits that follow it.
  logic [6:0] crc_rx;

  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      crc_rx  <= '0;
      crc_err <= 1'b0;
    end else begin
      if (accept) crc_err <= 1'b0;
      if (rx_begin)                          crc_rx <= '0;
      else if (rx_shift && bit_cnt < 6'd39)  crc_rx <= crc7_step(crc_rx, cmd_i);
      if (rx_last) crc_err <= (lat_type == 2'b01) && (crc_rx != rx_sr[6:0]);
    end
  end
`else
  assign crc_err = 1'b0;
`endif

endmodule
